// File: rtl/rdr_pkg.sv
// -----------------------------------------------------------------------------
// rdr_pkg
// Shared constants and types for the rose/delay responder.
//   RDR_MAX_LAT     : largest pulse delay the scheduler type can express
//   lat_t           : holds a latency value 0..RDR_MAX_LAT
//   RDR_LAT_HI_DEF  : default delay when start=1 at the rise of a
//   RDR_LAT_LO_DEF  : default delay when start=0 at the rise of a
//   RDR_CNT_W_DEF   : default statistics counter width
//   lat_legal()     : elaboration-time range check for a latency parameter
// -----------------------------------------------------------------------------
package rdr_pkg;

    localparam int RDR_MAX_LAT = 8;

    typedef logic [$clog2(RDR_MAX_LAT+1)-1:0] lat_t;

    localparam int RDR_LAT_HI_DEF = 1;
    localparam int RDR_LAT_LO_DEF = 2;
    localparam int RDR_CNT_W_DEF  = 16;

    function automatic bit lat_legal(input int lat, input int max_lat);
        return (lat >= 1) && (lat <= max_lat);
    endfunction

endpackage

// File: rtl/rdr_edge_det.sv
// -----------------------------------------------------------------------------
// rdr_edge_det
// Rising-edge detector with a synchronous, active-high reset. The history flop
// resets to 0, so a signal already high in the first cycle after reset is
// reported as a rise.
// Ports:
//   clk   in  : clock, posedge sampling
//   rst   in  : synchronous active-high reset
//   sig   in  : monitored signal
//   rise  out : combinational, high in the cycle sig is 1 and was 0 last cycle
// -----------------------------------------------------------------------------
module rdr_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values that existed before the clock edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/rose_delay_responder.sv
// -----------------------------------------------------------------------------
// rose_delay_responder
// Responder for the start-qualified rose/delay handshake. Every rising edge of
// a schedules one single-cycle pulse on b, LAT_HI cycles later when start is
// high at the rise and LAT_LO cycles later when it is low. A request whose
// slot is already taken, or whose pulse would directly follow another b
// pulse, is discarded and flagged on drop.
// Optional feature: define RDR_STATS_EN to build the saturating pulse/drop
// counters; without it both counter ports are tied to 0.
// Ports:
//   clk        in  : sole clock, posedge sampling
//   rst        in  : synchronous active-high reset
//   start      in  : delay select, only looked at in the cycle a rises
//   a          in  : request strobe, only its 0->1 transition matters
//   b          out : registered response pulse, one cycle wide
//   busy       out : registered, high while a pulse waits in the scheduler
//   drop       out : registered one-cycle flag, a pulse was discarded
//   pulse_cnt  out : pulses emitted, saturating (RDR_STATS_EN)
//   drop_cnt   out : pulses dropped, saturating (RDR_STATS_EN)
// -----------------------------------------------------------------------------
module rose_delay_responder
    import rdr_pkg::*;
#(
    parameter int LAT_HI  = RDR_LAT_HI_DEF,
    parameter int LAT_LO  = RDR_LAT_LO_DEF,
    parameter int MAX_LAT = RDR_MAX_LAT,
    parameter int CNT_W   = RDR_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             a,
    output logic             b,
    output logic             busy,
    output logic             drop,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    if (!lat_legal(LAT_HI, MAX_LAT) || !lat_legal(LAT_LO, MAX_LAT)) begin : g_bad_lat
        $error("rose_delay_responder: LAT_HI and LAT_LO must lie in 1..MAX_LAT");
    end
    if (MAX_LAT < 2 || MAX_LAT > RDR_MAX_LAT) begin : g_bad_max
        $error("rose_delay_responder: MAX_LAT must lie in 2..RDR_MAX_LAT");
    end

    localparam int IDX_W = $clog2(MAX_LAT);
    typedef logic [IDX_W-1:0] idx_t;

    logic               rise;
    logic [MAX_LAT-1:0] slot;
    logic [MAX_LAT-1:0] slot_shift;
    logic [MAX_LAT-1:0] slot_next;
    lat_t               lat;
    idx_t               tgt;
    logic               bypass;
    logic               want_emit;
    logic               b_next;
    logic               drop_a;
    logic               drop_b;

    rdr_edge_det u_edge_det (
        .clk  (clk),
        .rst  (rst),
        .sig  (a),
        .rise (rise)
    );

    // After an edge, slot[k] set means b is loaded with 1 at the (k+1)-th
    // following edge. A delay of L therefore lands in bit L-2 of the shifted
    // vector; L=1 has no slot and feeds the b flop directly.
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        lat        = start ? lat_t'(LAT_HI) : lat_t'(LAT_LO);
        tgt        = idx_t'(lat - lat_t'(2));
        slot_shift = slot >> 1;
        slot_next  = slot_shift;
        bypass     = 1'b0;
        drop_a     = 1'b0;

        if (rise) begin
            if (lat == lat_t'(1)) begin
                if (slot[0]) drop_a = 1'b1;
                else         bypass = 1'b1;
            end else begin
                if (slot_shift[tgt]) drop_a         = 1'b1;
                else                 slot_next[tgt] = 1'b1;
            end
        end

        // A pulse may only start while b is low, so each one is a clean rise;
        // one that would follow straight on from a pulse is discarded instead.
        want_emit = slot[0] | bypass;
        b_next    = want_emit & ~b;
        drop_b    = want_emit & b;
    end

    // NOTE: the scheduler itself is reset, not just the outputs, so nothing
    // queued before reset can surface afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '0;
            b    <= 1'b0;
            busy <= 1'b0;
            drop <= 1'b0;
        end else begin
            slot <= slot_next;
            b    <= b_next;
            busy <= |slot_next;
            drop <= drop_a | drop_b;
        end
    end

`ifdef RDR_STATS_EN
    logic [CNT_W-1:0] pulse_q;
    logic [CNT_W-1:0] drop_q;

    // At most one increment per counter per cycle, even when two pulses are
    // discarded in the same cycle; both stop at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_q <= '0;
            drop_q  <= '0;
        end else begin
            if (b_next && !(&pulse_q))            pulse_q <= pulse_q + CNT_W'(1);
            if ((drop_a || drop_b) && !(&drop_q)) drop_q  <= drop_q + CNT_W'(1);
        end
    end

    assign pulse_cnt = pulse_q;
    assign drop_cnt  = drop_q;
`else
    assign pulse_cnt = '0;
    assign drop_cnt  = '0;
`endif

endmodule

// File: tb/tb_rose_delay_responder.sv
// -----------------------------------------------------------------------------
// tb_rose_delay_responder
// Two responders share one stimulus stream: dut0 with the default delays
// (hi=1, lo=2, 16-bit counters) and dut1 with hi=3, lo=1 and 2-bit counters.
// The reference model keeps, per instance, a table of cycles at which a pulse
// is owed on b and derives every output from it each cycle.
// -----------------------------------------------------------------------------
module tb_rose_delay_responder;

    localparam int MAXL = 8;
    localparam int RING = 64;

`ifdef RDR_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        a;
    logic        start;
    logic        b0, busy0, drop0;
    logic [15:0] pc0, dc0;
    logic        b1, busy1, drop1;
    logic [1:0]  pc1, dc1;
    logic        mon_rise;

    rose_delay_responder u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b0),
        .busy      (busy0),
        .drop      (drop0),
        .pulse_cnt (pc0),
        .drop_cnt  (dc0)
    );

    rose_delay_responder #(.LAT_HI(3), .LAT_LO(1), .MAX_LAT(8), .CNT_W(2)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b1),
        .busy      (busy1),
        .drop      (drop1),
        .pulse_cnt (pc1),
        .drop_cnt  (dc1)
    );

    // Counts rises of b0 independently of the model.
    rdr_edge_det u_mon (
        .clk  (clk),
        .rst  (rst),
        .sig  (b0),
        .rise (mon_rise)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int edge_no  = 0;

    // ---------------- reference model ----------------
    int lat_hi [2] = '{1, 3};
    int lat_lo [2] = '{2, 1};
    int cnt_max[2] = '{65535, 3};

    bit owed[2][RING];     // owed[i][t % RING]: b must read 1 at sample t
    bit m_b[2], m_busy[2], m_drop[2];
    int m_pc[2], m_dc[2];
    bit m_prev_a;
    int m_b0_total = 0;
    int mon_total  = 0;

    function automatic int slot_of(input int t);
        return t % RING;
    endfunction

    // Sample t is the value seen just before posedge t, i.e. after edge t-1.
    // The edge being modelled is edge_no; its effect is visible at edge_no+1.
    function automatic void model_edge(input bit r, input bit av, input bit sv);
        for (int i = 0; i < 2; i++) begin
            bit rise_v, want, prev_b, drop_new;
            int lat;
            drop_new = 1'b0;
            if (r) begin
                for (int k = 0; k <= MAXL + 1; k++) owed[i][slot_of(edge_no + k)] = 1'b0;
                m_b[i]    = 1'b0;
                m_busy[i] = 1'b0;
                m_drop[i] = 1'b0;
                m_pc[i]   = 0;
                m_dc[i]   = 0;
            end else begin
                rise_v = av && !m_prev_a;
                if (rise_v) begin
                    lat = sv ? lat_hi[i] : lat_lo[i];
                    if (owed[i][slot_of(edge_no + lat)]) drop_new = 1'b1;
                    else                                 owed[i][slot_of(edge_no + lat)] = 1'b1;
                end
                want      = owed[i][slot_of(edge_no + 1)];
                prev_b    = m_b[i];
                m_b[i]    = want && !prev_b;
                m_drop[i] = drop_new || (want && prev_b);
                m_busy[i] = 1'b0;
                for (int k = 2; k <= MAXL; k++)
                    if (owed[i][slot_of(edge_no + k)]) m_busy[i] = 1'b1;
                if (m_b[i] && m_pc[i] < cnt_max[i]) m_pc[i]++;
                if (m_drop[i] && m_dc[i] < cnt_max[i]) m_dc[i]++;
                if (i == 0 && m_b[i]) m_b0_total++;
                owed[i][slot_of(edge_no + 1)] = 1'b0;
            end
        end
        m_prev_a = r ? 1'b0 : av;
        edge_no++;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, edge_no);
        end
    endtask

    task automatic compare_all();
        check("dut0.b",         64'(b0),    64'(m_b[0]));
        check("dut0.busy",      64'(busy0), 64'(m_busy[0]));
        check("dut0.drop",      64'(drop0), 64'(m_drop[0]));
        check("dut0.pulse_cnt", 64'(pc0),   STATS_EN ? 64'(m_pc[0]) : 64'd0);
        check("dut0.drop_cnt",  64'(dc0),   STATS_EN ? 64'(m_dc[0]) : 64'd0);
        check("dut1.b",         64'(b1),    64'(m_b[1]));
        check("dut1.busy",      64'(busy1), 64'(m_busy[1]));
        check("dut1.drop",      64'(drop1), 64'(m_drop[1]));
        check("dut1.pulse_cnt", 64'(pc1),   STATS_EN ? 64'(m_pc[1]) : 64'd0);
        check("dut1.drop_cnt",  64'(dc1),   STATS_EN ? 64'(m_dc[1]) : 64'd0);
        if (mon_rise === 1'b1) mon_total++;
    endtask

    // Drive inputs for one cycle, model the edge, compare on the falling edge.
    task automatic cycle(input bit r, input bit av, input bit sv);
        rst   = r;
        a     = av;
        start = sv;
        @(posedge clk);
        model_edge(r, av, sv);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit r_v, a_v, s_v;
        m_prev_a = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < RING; k++) owed[i][k] = 1'b0;
            m_b[i] = 1'b0; m_busy[i] = 1'b0; m_drop[i] = 1'b0;
            m_pc[i] = 0;   m_dc[i] = 0;
        end

        // Reset for three cycles.
        repeat (3) cycle(1'b1, 1'b0, 1'b0);
        check("reset_b",    64'(b0),    64'd0);
        check("reset_busy", 64'(busy0), 64'd0);
        check("reset_drop", 64'(drop0), 64'd0);
        check("reset_pcnt", 64'(pc0),   64'd0);
        check("reset_dcnt", 64'(dc0),   64'd0);

        // start=1: pulse one cycle after the rise, one cycle wide.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("hi_delay_b_high", 64'(b0), 64'd1);
        cycle(1'b0, 1'b0, 1'b1);
        check("hi_delay_b_low",  64'(b0), 64'd0);
        idle(4);
        check("hi_delay_pcnt", 64'(pc0), STATS_EN ? 64'd1 : 64'd0);

        // start=0: busy while pending, pulse two cycles after the rise.
        cycle(1'b0, 1'b1, 1'b0);
        check("lo_delay_busy",   64'(busy0), 64'd1);
        check("lo_delay_b_wait", 64'(b0),    64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("lo_delay_b_high", 64'(b0),    64'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("lo_delay_b_low",  64'(b0),    64'd0);
        idle(3);
        check("lo_delay_pcnt", 64'(pc0), STATS_EN ? 64'd2 : 64'd0);

        // Back-to-back pulses: the second would follow directly and is dropped.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        check("collb_first_b", 64'(b0), 64'd1);
        cycle(1'b0, 1'b1, 1'b1);
        check("collb_drop",    64'(drop0), 64'd1);
        check("collb_no_b",    64'(b0),    64'd0);
        cycle(1'b0, 1'b0, 1'b0);
        check("collb_drop_off", 64'(drop0), 64'd0);
        idle(3);
        check("collb_dcnt", 64'(dc0), STATS_EN ? 64'd1 : 64'd0);

        // dut1: hi=3 then lo=1 two cycles later both target the same cycle.
        cycle(1'b0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("colla_drop", 64'(drop1), 64'd1);
        check("colla_b",    64'(b1),    64'd1);
        cycle(1'b0, 1'b0, 1'b0);
        check("colla_b_once", 64'(b1), 64'd0);
        idle(4);

        // Reset one cycle before a pending lo-delay pulse would appear.
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("rst_pend_busy", 64'(busy0), 64'd0);
        for (int k = 0; k < 4; k++) begin
            check("rst_pend_no_b", 64'(b0), 64'd0);
            cycle(1'b0, 1'b0, 1'b0);
        end
        check("rst_pend_pcnt", 64'(pc0), 64'd0);
        check("rst_pend_dcnt", 64'(dc0), 64'd0);

        // Five accepted pulses: dut1's 2-bit counter stops at 3.
        for (int p = 0; p < 5; p++) begin
            cycle(1'b0, 1'b1, 1'b1);
            repeat (3) cycle(1'b0, 1'b0, 1'b1);
        end
        idle(3);
        check("sat_pcnt_dut1", 64'(pc1), STATS_EN ? 64'd3 : 64'd0);
        check("sat_pcnt_dut0", 64'(pc0), STATS_EN ? 64'd5 : 64'd0);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 2500; n++) begin
            r_v = ($urandom_range(0, 99) == 0);
            a_v = 1'($urandom_range(0, 1));
            s_v = 1'($urandom_range(0, 1));
            cycle(r_v, a_v, s_v);
        end
        idle(MAXL + 2);

        check("b0_rise_total", 64'(mon_total), 64'(m_b0_total));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
